// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state codes, counter
// limits, display widths (matching the SevenSegEncoder inputs) and the
// time-increment helper used by the live counters.
package stopwatch_pkg;

   // Display field widths shared with SevenSegEncoder
   localparam int MINS_W = 7;
   localparam int SECS_W = 6;
   localparam int DECS_W = 7;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_LAP     = 2'd2;
   localparam logic [1:0] ST_PAUSED  = 2'd3;

   // Roll-over points of the hundredths and seconds fields
   localparam logic [DECS_W-1:0] DECS_MAX = 7'd99;
   localparam logic [SECS_W-1:0] SECS_MAX = 6'd59;

   typedef struct packed {
      logic [MINS_W-1:0] mins;
      logic [SECS_W-1:0] secs;
      logic [DECS_W-1:0] decs;
   } sw_time_t;

   // Advance a time value by one hundredth with decs->secs->mins carries.
   // Saturation is handled by the caller, which never calls this at the limit.
   function automatic sw_time_t time_inc(input sw_time_t t);
      sw_time_t r;
      r = t;
      if (t.decs == DECS_MAX) begin
         r.decs = '0;
         if (t.secs == SECS_MAX) begin
            r.secs = '0;
            r.mins = t.mins + 7'd1;
         end else begin
            r.secs = t.secs + 6'd1;
         end
      end else begin
         r.decs = t.decs + 7'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_btn_sync_edge.sv
// Push-button conditioning: 2-FF synchroniser followed by a rising-edge
// detector. A held button produces exactly one single-cycle pulse; the
// pulse is visible combinationally after the second sync edge so the
// consuming FSM reacts on the third clock edge after the input rises.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic sync_1;
   logic sync_2;
   logic sync_prev;

   // Synchroniser chain plus one delayed copy for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         sync_1    <= btn;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
      end
   end

   assign pulse = sync_2 & ~sync_prev;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch time base: button conditioning, FSM (IDLE/RUNNING/LAP/PAUSED),
// 1/100 s prescaler, saturating mins/secs/hundredths counters, lap freeze
// registers and the registered display mux feeding SevenSegEncoder.
// Button events are single-cycle pulses; when both arrive in the same
// cycle, start/stop wins and lap/reset is discarded.
module stopwatch_controller
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 500000,
   parameter int MAX_MINS = 99
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_start_stop,
   input  logic              btn_lap_reset,
   output logic [MINS_W-1:0] stopwatch_unit_mins,
   output logic [SECS_W-1:0] stopwatch_unit_secs,
   output logic [DECS_W-1:0] stopwatch_unit_decs,
   output logic              running,
   output logic              lap_active,
   output logic              overflow,
   output logic [1:0]        state_dbg
);

   // Prescaler is at least one bit wide so TICK_DIV=1 stays legal
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic          ss_ev;
   logic          lr_ev;
   logic          lr_act;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          clear;
   logic          latch;
   logic          counting;
   logic          tick;
   logic          sat;
   logic [PW-1:0] presc;
   sw_time_t      live;
   sw_time_t      lap;
   sw_time_t      disp;

   btn_sync_edge u_sync_ss (
      .clk   (clk),
      .rst   (reset),
      .btn   (btn_start_stop),
      .pulse (ss_ev)
   );

   btn_sync_edge u_sync_lr (
      .clk   (clk),
      .rst   (reset),
      .btn   (btn_lap_reset),
      .pulse (lr_ev)
   );

   // start/stop has priority over a simultaneous lap/reset
   assign lr_act   = lr_ev & ~ss_ev;
   assign counting = (state == ST_RUNNING) || (state == ST_LAP);
   assign tick     = counting && (presc == PRESC_LAST);
   assign sat      = (live.mins == MINS_W'(MAX_MINS)) &&
                     (live.secs == SECS_MAX) &&
                     (live.decs == DECS_MAX);

   // Next-state decode plus the clear and lap-latch strobes
   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      latch     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ss_ev) state_nxt = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (ss_ev) begin
               state_nxt = ST_PAUSED;
            end else if (lr_act) begin
               state_nxt = ST_LAP;
               latch     = 1'b1;
            end
         end
         ST_LAP: begin
            if (ss_ev)       state_nxt = ST_PAUSED;
            else if (lr_act) state_nxt = ST_RUNNING;
         end
         ST_PAUSED: begin
            if (ss_ev) begin
               state_nxt = ST_RUNNING;
            end else if (lr_act) begin
               state_nxt = ST_IDLE;
               clear     = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Prescaler: advances only while counting, holds while paused
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         presc <= '0;
      else if (clear)    presc <= '0;
      else if (tick)     presc <= '0;
      else if (counting) presc <= presc + 1'b1;
   end

   // Live counters, saturating at MAX_MINS:59.99
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             live <= '0;
      else if (clear)        live <= '0;
      else if (tick && !sat) live <= time_inc(live);
   end

   // Sticky overflow: a tick arriving at saturation
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            overflow <= 1'b0;
      else if (clear)       overflow <= 1'b0;
      else if (tick && sat) overflow <= 1'b1;
   end

   // Lap registers capture the pre-tick live value on entry to LAP
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      lap <= '0;
      else if (latch) lap <= live;
   end

   // Registered display mux: frozen lap value in LAP, live otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 disp <= '0;
      else if (state == ST_LAP)  disp <= lap;
      else                       disp <= live;
   end

   assign stopwatch_unit_mins = disp.mins;
   assign stopwatch_unit_secs = disp.secs;
   assign stopwatch_unit_decs = disp.decs;
   assign running             = counting;
   assign lap_active          = (state == ST_LAP);
   assign state_dbg           = state;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller. Three instances share the
// inputs: dut_a (TICK_DIV=4), dut_b (TICK_DIV=1), dut_c (TICK_DIV=1,
// MAX_MINS=1). Expected display values are derived from elapsed tick
// counts and queued in a scoreboard when stimulus is driven.
module tb_stopwatch_controller;

   logic clk;
   logic reset;
   logic btn_ss;
   logic btn_lr;
   int   cyc;

   logic [6:0] mins_a, mins_b, mins_c;
   logic [5:0] secs_a, secs_b, secs_c;
   logic [6:0] decs_a, decs_b, decs_c;
   logic       running_a, running_b, running_c;
   logic       lap_a, lap_b, lap_c;
   logic       ovf_a, ovf_b, ovf_c;
   logic [1:0] st_a, st_b, st_c;

   logic [19:0] exp_q[$];
   int          checks;
   int          passed;

   stopwatch_controller #(.TICK_DIV(4), .MAX_MINS(99)) dut_a (
      .clk(clk), .reset(reset), .btn_start_stop(btn_ss), .btn_lap_reset(btn_lr),
      .stopwatch_unit_mins(mins_a), .stopwatch_unit_secs(secs_a),
      .stopwatch_unit_decs(decs_a), .running(running_a), .lap_active(lap_a),
      .overflow(ovf_a), .state_dbg(st_a)
   );

   stopwatch_controller #(.TICK_DIV(1), .MAX_MINS(99)) dut_b (
      .clk(clk), .reset(reset), .btn_start_stop(btn_ss), .btn_lap_reset(btn_lr),
      .stopwatch_unit_mins(mins_b), .stopwatch_unit_secs(secs_b),
      .stopwatch_unit_decs(decs_b), .running(running_b), .lap_active(lap_b),
      .overflow(ovf_b), .state_dbg(st_b)
   );

   stopwatch_controller #(.TICK_DIV(1), .MAX_MINS(1)) dut_c (
      .clk(clk), .reset(reset), .btn_start_stop(btn_ss), .btn_lap_reset(btn_lr),
      .stopwatch_unit_mins(mins_c), .stopwatch_unit_secs(secs_c),
      .stopwatch_unit_decs(decs_c), .running(running_c), .lap_active(lap_c),
      .overflow(ovf_c), .state_dbg(st_c)
   );

   // Clock and edge counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passed);
      $fatal(1, "watchdog");
   end

   // Expected display {mins,secs,decs} after t ticks, saturating at maxm:59.99
   function automatic logic [19:0] disp_of(input int t, input int maxm);
      int lim;
      lim = maxm * 6000 + 5999;
      if (t > lim) t = lim;
      return {7'(t / 6000), 6'((t / 100) % 60), 7'(t % 100)};
   endfunction

   // Wait until posedge n has happened; returns on the following negedge
   task automatic wait_edge(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic push_exp(input logic [19:0] v);
      exp_q.push_back(v);
   endtask

   // Scoreboard compare of a display value against the oldest expectation
   task automatic check_disp(input string tag, input logic [19:0] obs);
      logic [19:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         $error("FAIL %s: observed %0d:%0d.%0d but no expectation queued", tag,
                obs[19:13], obs[12:7], obs[6:0]);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) begin
            passed++;
         end else begin
            $error("FAIL %s: observed %0d:%0d.%0d expected %0d:%0d.%0d", tag,
                   obs[19:13], obs[12:7], obs[6:0], exp[19:13], exp[12:7], exp[6:0]);
         end
      end
   endtask

   task automatic check_val(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise the selected buttons, wait for the FSM edge, then release
   task automatic press(input logic ss, input logic lr, output int ev);
      btn_ss = ss;
      btn_lr = lr;
      ev = cyc + 3;
      wait_edge(ev);
      btn_ss = 1'b0;
      btn_lr = 1'b0;
   endtask

   initial begin
      int e, p, l, r, q;
      checks = 0;
      passed = 0;
      reset  = 1'b1;
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check_val("rst_disp_a", {mins_a, secs_a, decs_a}, 20'd0);
      check_val("rst_disp_b", {mins_b, secs_b, decs_b}, 20'd0);
      check_val("rst_flags_b", 20'({running_b, lap_b, ovf_b, st_b}), 20'd0);
      check_val("rst_flags_c", 20'({running_c, lap_c, ovf_c, st_c}), 20'd0);
      reset = 1'b0;
      @(negedge clk);

      // Test 1: TICK_DIV=4, start held 5 clks, 3-edge latency, 1.00 s
      btn_ss = 1'b1;
      e = cyc + 3;
      push_exp(disp_of(100, 99));
      push_exp(disp_of(401, 99));
      wait_edge(e - 1);
      check_val("t1_run_early", 20'(running_a), 20'd0);
      wait_edge(e);
      check_val("t1_run_edge3", 20'(running_a), 20'd1);
      wait_edge(e + 2);
      btn_ss = 1'b0;
      wait_edge(e + 402);
      check_disp("t1_disp_a", {mins_a, secs_a, decs_a});
      check_disp("t1_disp_b", {mins_b, secs_b, decs_b});

      // Test 4: pause holds the display, then lap/reset clears to IDLE
      press(1'b1, 1'b0, p);
      push_exp(disp_of(p - e, 99));
      push_exp(disp_of(p - e, 99));
      wait_edge(p + 2);
      check_disp("t4_pause", {mins_b, secs_b, decs_b});
      check_val("t4_state", 20'(st_b), 20'd3);
      wait_edge(p + 1000);
      check_disp("t4_pause_hold", {mins_b, secs_b, decs_b});
      check_val("t4_running", 20'(running_b), 20'd0);
      press(1'b0, 1'b1, q);
      wait_edge(q + 2);
      check_val("t4_clear_b", {mins_b, secs_b, decs_b}, 20'd0);
      check_val("t4_clear_a", {mins_a, secs_a, decs_a}, 20'd0);
      check_val("t4_clear_flags", 20'({running_b, lap_b, ovf_b, st_b}), 20'd0);

      // Test 2: TICK_DIV=1, 59.99 -> 1:00.00 with no intermediate glitch
      press(1'b1, 1'b0, e);
      push_exp(disp_of(5999, 99));
      push_exp(disp_of(6000, 99));
      push_exp(disp_of(6001, 99));
      wait_edge(e + 6000);
      check_disp("t2_5999", {mins_b, secs_b, decs_b});
      wait_edge(e + 6001);
      check_disp("t2_6000", {mins_b, secs_b, decs_b});
      wait_edge(e + 6002);
      check_disp("t2_6001", {mins_b, secs_b, decs_b});
      press(1'b1, 1'b0, p);
      press(1'b0, 1'b1, q);

      // Test 3: lap freezes the display at 2.50, release returns to live
      press(1'b1, 1'b0, e);
      wait_edge(e + 248);
      press(1'b0, 1'b1, l);
      push_exp(disp_of(250, 99));
      push_exp(disp_of(250, 99));
      wait_edge(l + 2);
      check_disp("t3_lap_frozen", {mins_b, secs_b, decs_b});
      check_val("t3_lap_flags", 20'({running_b, lap_b, st_b}), 20'b1110);
      wait_edge(l + 100);
      check_disp("t3_lap_hold", {mins_b, secs_b, decs_b});
      wait_edge(e + 400);
      press(1'b0, 1'b1, r);
      push_exp(disp_of(r - e, 99));
      check_val("t3_lap_off", 20'({running_b, lap_b}), 20'b10);
      wait_edge(r + 1);
      check_disp("t3_live", {mins_b, secs_b, decs_b});

      // Test 5: both buttons together -> PAUSED; long hold gives one event
      btn_ss = 1'b1;
      btn_lr = 1'b1;
      p = cyc + 3;
      push_exp(disp_of(p - e, 99));
      wait_edge(p - 1);
      btn_lr = 1'b0;
      wait_edge(p + 2);
      check_val("t5_both", 20'({running_b, lap_b, st_b}), 20'b0011);
      wait_edge(p + 100);
      check_val("t5_held", 20'(st_b), 20'd3);
      check_disp("t5_disp", {mins_b, secs_b, decs_b});
      btn_ss = 1'b0;
      press(1'b0, 1'b1, q);
      wait_edge(q + 2);
      check_val("t5_idle", {mins_b, secs_b, decs_b, st_b}, 22'd0);

      // Test 6: MAX_MINS=1 saturation and sticky overflow, then async reset
      press(1'b1, 1'b0, e);
      push_exp(disp_of(12000, 1));
      push_exp(disp_of(20000, 1));
      wait_edge(e + 11999);
      check_val("t6_ovf_early", 20'(ovf_c), 20'd0);
      wait_edge(e + 12001);
      check_disp("t6_sat", {mins_c, secs_c, decs_c});
      check_val("t6_ovf_set", 20'(ovf_c), 20'd1);
      check_val("t6_ovf_b", 20'(ovf_b), 20'd0);
      wait_edge(e + 12100);
      check_disp("t6_sat_hold", {mins_c, secs_c, decs_c});
      check_val("t6_still_run", 20'({running_c, ovf_c, st_c}), 20'b1101);
      #2;
      reset = 1'b1;
      #1;
      check_val("t6_async_c", {mins_c, secs_c, decs_c}, 20'd0);
      check_val("t6_async_flags", 20'({running_c, ovf_c, st_c}), 20'd0);
      check_val("t6_async_b", {mins_b, secs_b, decs_b}, 20'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
